hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_ni, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i, each 5 bits: source and destination register fields per stage.
REQ-004 SHALL have inputs RegWriteM_i, RegWriteW_i, LoadE_i, PCSrcE_i, FlushPred_i, MemReqM_i, MemReady_i, each 1 bit. LoadE_i flags a load in E; FlushPred_i is the predictor mispredict flush; MemReqM_i flags a data-memory access in M.
REQ-005 SHALL have outputs ForwardAE_o and ForwardBE_o, 2 bits each: 00 register file, 01 WB result, 10 M ALU result.
REQ-006 SHALL have 1-bit outputs StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o and MemErr_o.
REQ-007 SHALL have 32-bit outputs StallCnt_o and FlushCnt_o, present only under HAZARD_PERF_CNT_EN.

Function
REQ-008 SHALL compute forwarding combinationally: select 10 if RegWriteM_i, RdM_i!=0 and RdM_i==Rs1E_i; otherwise 01 if the same test holds for W; otherwise 00. M has priority over W. ForwardBE_o uses Rs2E_i with the same rules.
REQ-009 SHALL assert load-use stall (lw) when LoadE_i, RdE_i!=0 and RdE_i matches Rs1D_i or Rs2D_i. lw drives StallF_o=1, StallD_o=1 and FlushE_o=1.
REQ-010 SHALL treat redirect as PCSrcE_i|FlushPred_i. Redirect drives FlushD_o=1 and FlushE_o=1.
REQ-011 SHALL let redirect win if redirect and lw coincide: StallF_o=0 and StallD_o=0, with the flushes asserted.
REQ-012 SHALL implement a memory-wait FSM with three states: RUN, WAIT and ERR.
REQ-013 In RUN, if MemReqM_i=1 and MemReady_i=0, SHALL go to WAIT. This stall is Mealy and takes effect in the same cycle.
REQ-014 In WAIT, MemReady_i=1 SHALL release the stall in the same cycle and return to RUN.
REQ-015 WAIT SHALL increment an 8-bit wait counter each cycle. The counter clears on entry to WAIT.
REQ-016 If the wait counter equals MEM_TIMEOUT and MemReady_i=0, SHALL go to ERR. ERR is left only by reset.
REQ-017 While memory-stalled (RUN with the REQ-013 condition, WAIT with MemReady_i=0, or ERR), SHALL assert all Stall*_o=1 and FlushW_o=1, and force FlushD_o=0 and FlushE_o=0.
REQ-018 A redirect held during a memory stall SHALL take effect in the release cycle.
REQ-019 MemErr_o SHALL be 1 exactly in ERR.
REQ-020 StallE_o and StallM_o SHALL be asserted only by memory stall.
REQ-021 Forwarding outputs SHALL remain valid in all FSM states.

Reset
REQ-022 Reset SHALL set FSM=RUN, wait counter=0, MemErr_o=0 and both perf counters to 0.
REQ-023 With quiescent inputs at reset, all stall and flush outputs SHALL be 0.
REQ-024 Reset asserted mid-WAIT or in ERR SHALL take effect immediately and asynchronously.

Configuration
REQ-025 With HAZARD_PERF_CNT_EN defined, StallCnt_o SHALL increment once per cycle with StallF_o=1.
REQ-026 With HAZARD_PERF_CNT_EN defined, FlushCnt_o SHALL increment once per cycle with FlushD_o|FlushE_o=1.
REQ-027 Perf counters SHALL wrap modulo 2^32.
REQ-028 Without HAZARD_PERF_CNT_EN, the counter ports and counter logic SHALL be absent.

Structure
REQ-029 Package hazard_pkg SHALL hold the FSM state enum, the forward-select encodings (FWD_RF, FWD_WB, FWD_MEM) and MEM_TIMEOUT=8'd255.
REQ-030 Forwarding SHALL be a sub-module named forward_unit, instantiated once per ALU operand.

Verification
REQ-031 Bench SHALL drive RdM_i=5, RegWriteM_i=1, RdW_i=5, RegWriteW_i=1, Rs1E_i=5 and expect ForwardAE_o=10. With RdM_i=0 it SHALL expect 01.
REQ-032 Bench SHALL drive LoadE_i=1, RdE_i=7, Rs2D_i=7 and expect StallF_o=1, StallD_o=1, FlushE_o=1. With RdE_i=0 it SHALL expect all three 0.
REQ-033 Bench SHALL drive PCSrcE_i=1 together with the lw condition and expect FlushD_o=1, FlushE_o=1, StallF_o=0.
REQ-034 Bench SHALL drive MemReqM_i=1 with MemReady_i=0 for 3 cycles, then MemReady_i=1. It SHALL expect all Stall*_o=1 for 3 cycles, then 0 in the ready cycle, with FSM back in RUN.
REQ-035 Bench SHALL hold MemReady_i=0 for 300 cycles and expect MemErr_o=1 after 256 WAIT cycles, staying 1. Asserting reset_ni=0 SHALL clear MemErr_o immediately.
REQ-036 With HAZARD_PERF_CNT_EN defined, bench SHALL create 4 lw stalls and 2 redirects and expect StallCnt_o=4 and FlushCnt_o=6.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// memory-wait FSM states, forward-select encodings and the memory timeout.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } mem_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [7:0] MEM_TIMEOUT = 8'd255;

  // A later stage can supply rs only if it writes a non-zero register equal to rs.
  function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand bypass select for one ALU source: the M stage wins over the W stage,
// and the register file is used when neither stage writes the source register.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_mem,
  input  logic       reg_write_mem,
  input  logic [4:0] rd_wb,
  input  logic       reg_write_wb,
  output logic [1:0] fwd_sel
);

  // Priority select of the youngest producer
  always_comb begin
    fwd_sel = FWD_RF;
    if (fwd_hit(reg_write_mem, rd_mem, rs)) begin
      fwd_sel = FWD_MEM;
    end else if (fwd_hit(reg_write_wb, rd_wb, rs)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use stall, redirect flush and a
// memory-wait FSM with timeout. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_controller
  import hazard_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [4:0]  Rs1D_i,
  input  logic [4:0]  Rs2D_i,
  input  logic [4:0]  Rs1E_i,
  input  logic [4:0]  Rs2E_i,
  input  logic [4:0]  RdE_i,
  input  logic [4:0]  RdM_i,
  input  logic [4:0]  RdW_i,
  input  logic        RegWriteM_i,
  input  logic        RegWriteW_i,
  input  logic        LoadE_i,
  input  logic        PCSrcE_i,
  input  logic        FlushPred_i,
  input  logic        MemReqM_i,
  input  logic        MemReady_i,
  output logic [1:0]  ForwardAE_o,
  output logic [1:0]  ForwardBE_o,
  output logic        StallF_o,
  output logic        StallD_o,
  output logic        StallE_o,
  output logic        StallM_o,
  output logic        FlushD_o,
  output logic        FlushE_o,
  output logic        FlushW_o,
  output logic        MemErr_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt_o,
  output logic [31:0] FlushCnt_o
`endif
);

  mem_state_e state_r;
  mem_state_e state_nxt_s;
  logic [7:0] wait_cnt_r;
  logic [7:0] wait_cnt_nxt_s;
  logic       mem_stall_s;
  logic       redirect_s;
  logic       load_use_s;

  forward_unit u_fwd_a (
    .rs            (Rs1E_i),
    .rd_mem        (RdM_i),
    .reg_write_mem (RegWriteM_i),
    .rd_wb         (RdW_i),
    .reg_write_wb  (RegWriteW_i),
    .fwd_sel       (ForwardAE_o)
  );

  forward_unit u_fwd_b (
    .rs            (Rs2E_i),
    .rd_mem        (RdM_i),
    .reg_write_mem (RegWriteM_i),
    .rd_wb         (RdW_i),
    .reg_write_wb  (RegWriteW_i),
    .fwd_sel       (ForwardBE_o)
  );

  assign redirect_s = PCSrcE_i | FlushPred_i;
  assign load_use_s = LoadE_i && (RdE_i != 5'd0) && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  // Memory-wait state and wait counter registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Next state; the stall is Mealy so a late ready releases in the same cycle
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    mem_stall_s    = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (MemReqM_i && !MemReady_i) begin
          state_nxt_s    = ST_WAIT;
          wait_cnt_nxt_s = 8'd0;
          mem_stall_s    = 1'b1;
        end else begin
          state_nxt_s    = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (MemReady_i) begin
          state_nxt_s    = ST_RUN;
        end else if (wait_cnt_r == MEM_TIMEOUT) begin
          state_nxt_s    = ST_ERR;
          mem_stall_s    = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
          mem_stall_s    = 1'b1;
        end
      end
      ST_ERR: begin
        state_nxt_s = ST_ERR;
        mem_stall_s = 1'b1;
      end
      default: begin
        state_nxt_s    = ST_RUN;
        wait_cnt_nxt_s = 8'd0;
        mem_stall_s    = 1'b0;
      end
    endcase
  end

  // Stall/flush arbitration: memory stall freezes everything, redirect beats load-use
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushW_o = 1'b0;
    if (mem_stall_s) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushW_o = 1'b1;
    end else if (redirect_s) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else if (load_use_s) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      FlushE_o = 1'b1;
    end else begin
      StallF_o = 1'b0;
    end
  end

  assign MemErr_o = (state_r == ST_ERR);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Free-running event counters, wrapping modulo 2^32
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (StallF_o) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (FlushD_o || FlushE_o) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end
    end
  end

  assign StallCnt_o = stall_cnt_r;
  assign FlushCnt_o = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: per-cycle comparison against a
// behavioural model, pinned directed cases, then randomized stimulus.
module tb_hazard_controller;

  logic        clk_i;
  logic        reset_ni;
  logic [4:0]  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic        RegWriteM_i, RegWriteW_i, LoadE_i, PCSrcE_i, FlushPred_i, MemReqM_i, MemReady_i;
  logic [1:0]  ForwardAE_o, ForwardBE_o;
  logic        StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o, MemErr_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt_o, FlushCnt_o;
  logic [31:0] m_stall_cnt, m_flush_cnt;
`endif

  int checks;
  int failures;

  // Model of the memory side: waiting for data, how many WAIT cycles elapsed, error latched
  bit m_waiting;
  bit m_err;
  int m_waited;

  hazard_controller dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .Rs1D_i      (Rs1D_i),
    .Rs2D_i      (Rs2D_i),
    .Rs1E_i      (Rs1E_i),
    .Rs2E_i      (Rs2E_i),
    .RdE_i       (RdE_i),
    .RdM_i       (RdM_i),
    .RdW_i       (RdW_i),
    .RegWriteM_i (RegWriteM_i),
    .RegWriteW_i (RegWriteW_i),
    .LoadE_i     (LoadE_i),
    .PCSrcE_i    (PCSrcE_i),
    .FlushPred_i (FlushPred_i),
    .MemReqM_i   (MemReqM_i),
    .MemReady_i  (MemReady_i),
    .ForwardAE_o (ForwardAE_o),
    .ForwardBE_o (ForwardBE_o),
    .StallF_o    (StallF_o),
    .StallD_o    (StallD_o),
    .StallE_o    (StallE_o),
    .StallM_o    (StallM_o),
    .FlushD_o    (FlushD_o),
    .FlushE_o    (FlushE_o),
    .FlushW_o    (FlushW_o),
    .MemErr_o    (MemErr_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt_o  (StallCnt_o),
    .FlushCnt_o  (FlushCnt_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (RegWriteM_i && RdM_i != 5'd0 && RdM_i == rs) return 2'b10;
    if (RegWriteW_i && RdW_i != 5'd0 && RdW_i == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Packed as {fa[1:0], fb[1:0], sf, sd, se, sm, fd, fe, fw, err}
  function automatic logic [11:0] model_out();
    bit mem_stalled, redirect, lw;
    logic sf, sd, se, sm, fd, fe, fw;
    mem_stalled = m_err || (m_waiting ? !MemReady_i : (MemReqM_i && !MemReady_i));
    redirect    = PCSrcE_i || FlushPred_i;
    lw          = LoadE_i && RdE_i != 5'd0 && (RdE_i == Rs1D_i || RdE_i == Rs2D_i);
    if (mem_stalled) begin
      {sf, sd, se, sm, fd, fe, fw} = 7'b1111001;
    end else begin
      sf = lw && !redirect;
      sd = sf;
      se = 1'b0;
      sm = 1'b0;
      fd = redirect;
      fe = redirect || lw;
      fw = 1'b0;
    end
    return {model_fwd(Rs1E_i), model_fwd(Rs2E_i), sf, sd, se, sm, fd, fe, fw, m_err};
  endfunction

  task automatic model_reset();
    m_waiting = 1'b0;
    m_err     = 1'b0;
    m_waited  = 0;
`ifdef HAZARD_PERF_CNT_EN
    m_stall_cnt = 32'd0;
    m_flush_cnt = 32'd0;
`endif
  endtask

  task automatic model_update(input logic [11:0] o);
    if (!reset_ni) begin
      model_reset();
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (o[7]) m_stall_cnt = m_stall_cnt + 32'd1;
      if (o[3] || o[2]) m_flush_cnt = m_flush_cnt + 32'd1;
`endif
      if (m_err) begin
        m_err = 1'b1;
      end else if (m_waiting) begin
        if (MemReady_i) begin
          m_waiting = 1'b0;
        end else begin
          m_waited = m_waited + 1;
          if (m_waited == 256) m_err = 1'b1;
        end
      end else if (MemReqM_i && !MemReady_i) begin
        m_waiting = 1'b1;
        m_waited  = 0;
      end
    end
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // One clock: compare against the model mid-cycle, then advance the model on the edge
  task automatic step();
    logic [11:0] exp_v;
    logic [11:0] got_v;
    if (!reset_ni) model_reset();
    @(negedge clk_i);
    exp_v = model_out();
    got_v = {ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, StallE_o, StallM_o,
             FlushD_o, FlushE_o, FlushW_o, MemErr_o};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL outputs got=%h expected=%h t=%0t", got_v, exp_v, $time);
    end
`ifdef HAZARD_PERF_CNT_EN
    pin("stall_cnt_model", StallCnt_o, m_stall_cnt);
    pin("flush_cnt_model", FlushCnt_o, m_flush_cnt);
`endif
    @(posedge clk_i);
    model_update(exp_v);
    #1;
  endtask

  task automatic set_quiet();
    {Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i} = 35'd0;
    {RegWriteM_i, RegWriteW_i, LoadE_i, PCSrcE_i, FlushPred_i, MemReqM_i, MemReady_i} = 7'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_ni = 1'b0;
    set_quiet();
    model_reset();
    #2;
    pin("reset_stall_flush", 32'({StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o}), 32'd0);
    pin("reset_memerr", 32'(MemErr_o), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    pin("reset_cnts", StallCnt_o | FlushCnt_o, 32'd0);
`endif
    step();
    step();
    reset_ni = 1'b1;
    step();

    // Forwarding priority
    RdM_i = 5'd5; RegWriteM_i = 1'b1; RdW_i = 5'd5; RegWriteW_i = 1'b1; Rs1E_i = 5'd5; Rs2E_i = 5'd5;
    #2; pin("fwdA_mem", 32'(ForwardAE_o), 32'd2);
    step();
    RdM_i = 5'd0;
    #2; pin("fwdA_wb", 32'(ForwardAE_o), 32'd1);
    pin("fwdB_wb", 32'(ForwardBE_o), 32'd1);
    step();

    // Load-use
    set_quiet();
    LoadE_i = 1'b1; RdE_i = 5'd7; Rs2D_i = 5'd7;
    #2; pin("lw_stall", 32'({StallF_o, StallD_o, FlushE_o}), 32'd7);
    step();
    RdE_i = 5'd0;
    #2; pin("lw_x0", 32'({StallF_o, StallD_o, FlushE_o}), 32'd0);
    step();

    // Redirect beats load-use
    RdE_i = 5'd7; PCSrcE_i = 1'b1;
    #2; pin("redirect_lw", 32'({FlushD_o, FlushE_o, StallF_o, StallD_o}), 32'd12);
    step();
    set_quiet();
    FlushPred_i = 1'b1;
    #2; pin("flush_pred", 32'({FlushD_o, FlushE_o}), 32'd3);
    step();

    // Three-cycle memory wait then release
    set_quiet();
    MemReqM_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2; pin("memwait_stall", 32'({StallF_o, StallD_o, StallE_o, StallM_o, FlushW_o}), 32'd31);
      step();
    end
    MemReady_i = 1'b1;
    #2; pin("mem_release", 32'({StallF_o, StallD_o, StallE_o, StallM_o, FlushW_o}), 32'd0);
    step();
    MemReqM_i = 1'b0; MemReady_i = 1'b0;
    #2; pin("back_in_run", 32'({StallF_o, StallE_o}), 32'd0);
    step();

    // Redirect held across a memory stall lands in the release cycle
    MemReqM_i = 1'b1; PCSrcE_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2; pin("redirect_held", 32'({FlushD_o, FlushE_o, StallF_o}), 32'd1);
      step();
    end
    MemReady_i = 1'b1;
    #2; pin("redirect_release", 32'({FlushD_o, FlushE_o, StallF_o}), 32'd6);
    step();
    set_quiet();
    step();

    // Timeout into ERR, sticky until an asynchronous reset
    MemReqM_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #2;
      if (i == 256) pin("err_not_yet", 32'(MemErr_o), 32'd0);
      if (i == 257) pin("err_set", 32'(MemErr_o), 32'd1);
      step();
    end
    pin("err_hold", 32'(MemErr_o), 32'd1);
    MemReqM_i = 1'b0; MemReady_i = 1'b1;
    #2; pin("err_sticky", 32'({MemErr_o, StallF_o}), 32'd3);
    step();
    #2; reset_ni = 1'b0;
    #1; pin("err_async_clear", 32'(MemErr_o), 32'd0);
    pin("reset_release_stall", 32'({StallF_o, StallM_o, FlushW_o}), 32'd0);
    step();
    step();
    reset_ni = 1'b1;
    set_quiet();
    step();

`ifdef HAZARD_PERF_CNT_EN
    // Four load-use stalls and two redirects from a freshly reset counter
    for (int k = 0; k < 4; k++) begin
      LoadE_i = 1'b1; RdE_i = 5'd7; Rs1D_i = 5'd7;
      step();
      set_quiet();
      step();
    end
    for (int k = 0; k < 2; k++) begin
      PCSrcE_i = 1'b1;
      step();
      set_quiet();
      step();
    end
    #2;
    pin("stall_cnt_4", StallCnt_o, 32'd4);
    pin("flush_cnt_6", FlushCnt_o, 32'd6);
`endif

    // Randomized traffic with a narrow register range to provoke hazards
    for (int n = 0; n < 600; n++) begin
      Rs1D_i = 5'($urandom_range(0, 3));
      Rs2D_i = 5'($urandom_range(0, 3));
      Rs1E_i = 5'($urandom_range(0, 3));
      Rs2E_i = 5'($urandom_range(0, 3));
      RdE_i  = 5'($urandom_range(0, 3));
      RdM_i  = 5'($urandom_range(0, 3));
      RdW_i  = 5'($urandom_range(0, 3));
      RegWriteM_i = 1'($urandom_range(0, 1));
      RegWriteW_i = 1'($urandom_range(0, 1));
      LoadE_i     = 1'($urandom_range(0, 1));
      PCSrcE_i    = ($urandom_range(0, 5) == 0);
      FlushPred_i = ($urandom_range(0, 7) == 0);
      MemReqM_i   = ($urandom_range(0, 3) == 0);
      MemReady_i  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
